// File: rtl/emmc_rd_checker.sv
// Readback checker for the eMMC read byte stream. It compares each byte with the 55/AA checkerboard
// and reports done/pass/fail per transfer plus error counters. Define EMMC_RD_CHK_FIRST_ERR_EN for first-mismatch capture.
module emmc_rd_checker #(
    parameter int LENGTH = 1024,
    parameter int ERR_W  = 16
) (
    input  logic             clk_core,
    input  logic             rst_tk,
    input  logic             run_i,
    input  logic             we_i,
    input  logic             dvalid_i,
    input  logic [7:0]       dat_i,
    input  logic             ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic             fail_o,
    output logic [ERR_W-1:0] xfer_err_cnt_o,
    output logic [ERR_W-1:0] total_err_cnt_o,
`ifdef EMMC_RD_CHK_FIRST_ERR_EN
    output logic             first_err_vld_o,
    output logic [15:0]      first_err_idx_o,
    output logic [7:0]       first_err_exp_o,
    output logic [7:0]       first_err_act_o,
`endif
    output logic [15:0]      xfer_cnt_o
);

    localparam int IDX_W = $clog2(LENGTH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LENGTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0] ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        if (v == ERR_MAX) begin
            sat_inc = v;
        end else begin
            sat_inc = v + ERR_ONE;
        end
    endfunction

    state_t           state_r, state_nxt_s;
    logic [IDX_W-1:0] idx_r, idx_nxt_s, idx_inc_s;
    logic             short_r, short_nxt_s;
    logic [ERR_W-1:0] run_err_r;
    logic             acc_s, chk_s, mis_s, ovr_s;
    logic [7:0]       exp_s;

    logic             busy_r, done_r, pass_r, fail_r;
    logic [ERR_W-1:0] xfer_err_r, total_err_r;
    logic [15:0]      xfer_cnt_r;

    // Byte acceptance and comparison against the checkerboard.
    always_comb begin
        acc_s     = run_i & ~we_i & dvalid_i;
        exp_s     = idx_r[0] ? 8'hAA : 8'h55;
        chk_s     = acc_s & (state_r != ST_REPORT);
        mis_s     = chk_s & (dat_i != exp_s);
        ovr_s     = acc_s & (state_r == ST_REPORT);
        idx_inc_s = idx_r + IDX_ONE;
    end

    // Next state, byte index and short-transfer flag.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        short_nxt_s = short_r;
        case (state_r)
            ST_IDLE: begin
                if (acc_s) begin
                    state_nxt_s = ST_CHECK;
                    idx_nxt_s   = idx_inc_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (acc_s) begin
                    idx_nxt_s = idx_inc_s;
                    if (idx_r == LAST_IDX) begin
                        state_nxt_s = ST_REPORT;
                    end else if (ready_i) begin
                        // Boundary seen before the final byte arrived: transfer was cut short.
                        state_nxt_s = ST_REPORT;
                        short_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_CHECK;
                    end
                end else if (ready_i) begin
                    state_nxt_s = ST_REPORT;
                    short_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_CHECK;
                end
            end
            ST_REPORT: begin
                state_nxt_s = ST_IDLE;
                idx_nxt_s   = {IDX_W{1'b0}};
                short_nxt_s = 1'b0;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                idx_nxt_s   = {IDX_W{1'b0}};
                short_nxt_s = 1'b0;
            end
        endcase
    end

    // FSM state, index and short flag registers.
    always_ff @(posedge clk_core or posedge rst_tk) begin
        if (rst_tk) begin
            state_r <= ST_IDLE;
            idx_r   <= {IDX_W{1'b0}};
            short_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
            short_r <= short_nxt_s;
        end
    end

    // Running per-transfer and lifetime mismatch counters.
    always_ff @(posedge clk_core or posedge rst_tk) begin
        if (rst_tk) begin
            run_err_r   <= {ERR_W{1'b0}};
            total_err_r <= {ERR_W{1'b0}};
        end else begin
            if (state_r == ST_REPORT) begin
                run_err_r <= {ERR_W{1'b0}};
            end else if (mis_s) begin
                run_err_r <= sat_inc(run_err_r);
            end else begin
                run_err_r <= run_err_r;
            end
            if (mis_s || ovr_s) begin
                total_err_r <= sat_inc(total_err_r);
            end else begin
                total_err_r <= total_err_r;
            end
        end
    end

    // Transfer result registers, refreshed when leaving REPORT.
    always_ff @(posedge clk_core or posedge rst_tk) begin
        if (rst_tk) begin
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
            fail_r     <= 1'b0;
            xfer_err_r <= {ERR_W{1'b0}};
            xfer_cnt_r <= 16'd0;
        end else begin
            busy_r <= (state_nxt_s == ST_CHECK);
            done_r <= (state_r == ST_REPORT);
            if (state_r == ST_REPORT) begin
                pass_r     <= ~short_r & (run_err_r == {ERR_W{1'b0}});
                fail_r     <= short_r | (run_err_r != {ERR_W{1'b0}});
                xfer_err_r <= run_err_r;
                xfer_cnt_r <= xfer_cnt_r + 16'd1;
            end else begin
                pass_r     <= pass_r;
                fail_r     <= fail_r;
                xfer_err_r <= xfer_err_r;
                xfer_cnt_r <= xfer_cnt_r;
            end
        end
    end

    assign busy_o          = busy_r;
    assign done_o          = done_r;
    assign pass_o          = pass_r;
    assign fail_o          = fail_r;
    assign xfer_err_cnt_o  = xfer_err_r;
    assign total_err_cnt_o = total_err_r;
    assign xfer_cnt_o      = xfer_cnt_r;

`ifdef EMMC_RD_CHK_FIRST_ERR_EN
    logic        fe_vld_r;
    logic [15:0] fe_idx_r;
    logic [7:0]  fe_exp_r, fe_act_r;

    // Sticky capture of the first compare mismatch since reset.
    always_ff @(posedge clk_core or posedge rst_tk) begin
        if (rst_tk) begin
            fe_vld_r <= 1'b0;
            fe_idx_r <= 16'd0;
            fe_exp_r <= 8'h00;
            fe_act_r <= 8'h00;
        end else if (mis_s && !fe_vld_r) begin
            fe_vld_r <= 1'b1;
            fe_idx_r <= 16'(idx_r);
            fe_exp_r <= exp_s;
            fe_act_r <= dat_i;
        end else begin
            fe_vld_r <= fe_vld_r;
            fe_idx_r <= fe_idx_r;
            fe_exp_r <= fe_exp_r;
            fe_act_r <= fe_act_r;
        end
    end

    assign first_err_vld_o = fe_vld_r;
    assign first_err_idx_o = fe_idx_r;
    assign first_err_exp_o = fe_exp_r;
    assign first_err_act_o = fe_act_r;
`endif

endmodule

// File: tb/tb_emmc_rd_checker.sv
// Randomized self-checking bench for emmc_rd_checker: a default instance plus a saturating ERR_W=4 instance,
// both compared every cycle against a transfer-level reference model.
module tb_emmc_rd_checker;

    localparam int L = 1024;

    logic        clk_core = 1'b0;
    logic        rst_tk   = 1'b1;
    logic        run_i = 1'b0, we_i = 1'b0, dvalid_i = 1'b0, ready_i = 1'b0;
    logic [7:0]  dat_i = 8'h00;

    logic        busy0, done0, pass0, fail0, busy1, done1, pass1, fail1;
    logic [15:0] xerr0, tot0, xcnt0, xcnt1;
    logic [3:0]  xerr1, tot1;
`ifdef EMMC_RD_CHK_FIRST_ERR_EN
    logic        fv0, fv1;
    logic [15:0] fi0, fi1;
    logic [7:0]  fe0, fe1, fa0, fa1;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    // reference model state, index 0 = default instance, 1 = ERR_W=4 instance
    int          m_phase[2];   // 0 waiting, 1 inside transfer, 2 transfer ended, result due
    int          m_idx[2];
    int          m_rerr[2];
    bit          m_short[2];
    int          m_max[2];
    logic [31:0] e_busy[2], e_done[2], e_pass[2], e_fail[2], e_xerr[2], e_tot[2], e_xcnt[2];
    logic [31:0] e_fv[2], e_fi[2], e_fe[2], e_fa[2];

    always #5 clk_core = ~clk_core;

    emmc_rd_checker #(.LENGTH(L), .ERR_W(16)) dut (
        .clk_core(clk_core), .rst_tk(rst_tk), .run_i(run_i), .we_i(we_i), .dvalid_i(dvalid_i),
        .dat_i(dat_i), .ready_i(ready_i), .busy_o(busy0), .done_o(done0), .pass_o(pass0), .fail_o(fail0),
        .xfer_err_cnt_o(xerr0), .total_err_cnt_o(tot0),
`ifdef EMMC_RD_CHK_FIRST_ERR_EN
        .first_err_vld_o(fv0), .first_err_idx_o(fi0), .first_err_exp_o(fe0), .first_err_act_o(fa0),
`endif
        .xfer_cnt_o(xcnt0)
    );

    emmc_rd_checker #(.LENGTH(L), .ERR_W(4)) dut_sat (
        .clk_core(clk_core), .rst_tk(rst_tk), .run_i(run_i), .we_i(we_i), .dvalid_i(dvalid_i),
        .dat_i(dat_i), .ready_i(ready_i), .busy_o(busy1), .done_o(done1), .pass_o(pass1), .fail_o(fail1),
        .xfer_err_cnt_o(xerr1), .total_err_cnt_o(tot1),
`ifdef EMMC_RD_CHK_FIRST_ERR_EN
        .first_err_vld_o(fv1), .first_err_idx_o(fi1), .first_err_exp_o(fe1), .first_err_act_o(fa1),
`endif
        .xfer_cnt_o(xcnt1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] pattern(input int k);
        return (k % 2 == 1) ? 8'hAA : 8'h55;
    endfunction

    function automatic int sat(input int v, input int m);
        return (v >= m_max[m]) ? m_max[m] : v + 1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_phase[m] = 0; m_idx[m] = 0; m_rerr[m] = 0; m_short[m] = 1'b0;
            e_busy[m] = 0; e_done[m] = 0; e_pass[m] = 0; e_fail[m] = 0;
            e_xerr[m] = 0; e_tot[m] = 0; e_xcnt[m] = 0;
            e_fv[m] = 0; e_fi[m] = 0; e_fe[m] = 0; e_fa[m] = 0;
        end
    endtask

    // One clock edge of the transfer-level rules, applied to the inputs sampled at that edge.
    task automatic model_step();
        bit acc;
        int was;
        acc = run_i & ~we_i & dvalid_i;
        for (int m = 0; m < 2; m++) begin
            e_done[m] = 0;
            if (m_phase[m] == 2) begin
                if (acc) e_tot[m] = sat(e_tot[m], m);
                e_done[m] = 1;
                e_pass[m] = (!m_short[m] && m_rerr[m] == 0) ? 1 : 0;
                e_fail[m] = (m_short[m] || m_rerr[m] != 0) ? 1 : 0;
                e_xerr[m] = m_rerr[m];
                e_xcnt[m] = (e_xcnt[m] + 1) & 32'hFFFF;
                m_phase[m] = 0; m_idx[m] = 0; m_rerr[m] = 0; m_short[m] = 1'b0;
            end else begin
                was = m_phase[m];
                if (acc) begin
                    if (dat_i != pattern(m_idx[m])) begin
                        m_rerr[m] = sat(m_rerr[m], m);
                        e_tot[m]  = sat(e_tot[m], m);
                        if (e_fv[m] == 0) begin
                            e_fv[m] = 1; e_fi[m] = m_idx[m]; e_fe[m] = pattern(m_idx[m]); e_fa[m] = dat_i;
                        end
                    end
                    m_idx[m]++;
                end
                if (was == 1 && acc && m_idx[m] == L) m_phase[m] = 2;
                else if (was == 1 && ready_i) begin
                    m_phase[m] = 2;
                    m_short[m] = 1'b1;
                end else if (acc) m_phase[m] = 1;
            end
            e_busy[m] = (m_phase[m] == 1) ? 1 : 0;
        end
    endtask

    task automatic compare_all();
        check_eq("d0_busy", 32'(busy0), e_busy[0]);
        check_eq("d0_done", 32'(done0), e_done[0]);
        check_eq("d0_pass", 32'(pass0), e_pass[0]);
        check_eq("d0_fail", 32'(fail0), e_fail[0]);
        check_eq("d0_xerr", 32'(xerr0), e_xerr[0]);
        check_eq("d0_total", 32'(tot0), e_tot[0]);
        check_eq("d0_xcnt", 32'(xcnt0), e_xcnt[0]);
        check_eq("d1_busy", 32'(busy1), e_busy[1]);
        check_eq("d1_done", 32'(done1), e_done[1]);
        check_eq("d1_pass", 32'(pass1), e_pass[1]);
        check_eq("d1_fail", 32'(fail1), e_fail[1]);
        check_eq("d1_xerr", 32'(xerr1), e_xerr[1]);
        check_eq("d1_total", 32'(tot1), e_tot[1]);
        check_eq("d1_xcnt", 32'(xcnt1), e_xcnt[1]);
`ifdef EMMC_RD_CHK_FIRST_ERR_EN
        check_eq("d0_fe_vld", 32'(fv0), e_fv[0]);
        check_eq("d0_fe_idx", 32'(fi0), e_fi[0]);
        check_eq("d0_fe_exp", 32'(fe0), e_fe[0]);
        check_eq("d0_fe_act", 32'(fa0), e_fa[0]);
        check_eq("d1_fe_vld", 32'(fv1), e_fv[1]);
        check_eq("d1_fe_idx", 32'(fi1), e_fi[1]);
`endif
    endtask

    task automatic cyc(input logic run, input logic we, input logic dv, input logic [7:0] d, input logic rdy);
        @(negedge clk_core);
        run_i = run; we_i = we; dvalid_i = dv; dat_i = d; ready_i = rdy;
        @(posedge clk_core);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle_cyc();
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic good_bytes(input int n);
        for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 1'b1, pattern(k), 1'b0);
    endtask

    task automatic do_reset();
        #2;
        rst_tk = 1'b1;
        run_i = 1'b0; we_i = 1'b0; dvalid_i = 1'b0; dat_i = 8'h00; ready_i = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk_core);
        #1;
        compare_all();
        @(negedge clk_core);
        rst_tk = 1'b0;
    endtask

    initial begin
        model_reset();
        m_max[0] = 65535;
        m_max[1] = 15;
        repeat (3) @(posedge clk_core);
        #1;
        compare_all();
        @(negedge clk_core);
        rst_tk = 1'b0;

        // clean full transfer
        good_bytes(L);
        idle_cyc();
        check_eq("t1_done", 32'(done0), 32'd1);
        check_eq("t1_pass", 32'(pass0), 32'd1);
        check_eq("t1_xerr", 32'(xerr0), 32'd0);
        idle_cyc();
        check_eq("t1_done_clr", 32'(done0), 32'd0);

        // two corrupted bytes at index 10 and 11
        for (int k = 0; k < L; k++)
            cyc(1'b1, 1'b0, 1'b1, (k == 10 || k == 11) ? 8'h00 : pattern(k), 1'b0);
        idle_cyc();
        check_eq("t2_xerr", 32'(xerr0), 32'd2);
        check_eq("t2_fail", 32'(fail0), 32'd1);
        check_eq("t2_total", 32'(tot0), 32'd2);
`ifdef EMMC_RD_CHK_FIRST_ERR_EN
        check_eq("t2_fe_idx", 32'(fi0), 32'd10);
        check_eq("t2_fe_exp", 32'(fe0), 32'h55);
        check_eq("t2_fe_act", 32'(fa0), 32'h00);
`endif
        idle_cyc();

        // short transfer ended by ready_i, then a full transfer from index 0
        good_bytes(600);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        idle_cyc();
        check_eq("t3_fail", 32'(fail0), 32'd1);
        check_eq("t3_xerr", 32'(xerr0), 32'd0);
        check_eq("t3_xcnt", 32'(xcnt0), 32'd3);
        good_bytes(L);
        idle_cyc();
        check_eq("t3b_pass", 32'(pass0), 32'd1);

        // ignored bytes (write phase or run low) interleaved with a clean read
        for (int k = 0; k < L; k++) begin
            if ($urandom_range(0, 3) == 0)
                cyc($urandom_range(0, 1) == 1, 1'b1, 1'b1, 8'($urandom), 1'b0);
            if ($urandom_range(0, 3) == 0)
                cyc(1'b0, 1'b0, 1'b1, 8'($urandom), 1'b0);
            cyc(1'b1, 1'b0, 1'b1, pattern(k), 1'b0);
        end
        idle_cyc();
        check_eq("t4_pass", 32'(pass0), 32'd1);
        idle_cyc();

        // all-zero transfer saturates the narrow counters
        for (int k = 0; k < L; k++) cyc(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        idle_cyc();
        check_eq("t5_xerr_sat", 32'(xerr1), 32'd15);
        check_eq("t5_total_sat", 32'(tot1), 32'd15);
        check_eq("t5_xerr_wide", 32'(xerr0), 32'd1024);
        idle_cyc();

        // random traffic including overruns, gaps and early boundaries
        for (int c = 0; c < 5000; c++) begin
            logic r, w, v, rdy;
            logic [7:0] d;
            r   = ($urandom_range(0, 19) != 0);
            w   = ($urandom_range(0, 19) == 0);
            v   = ($urandom_range(0, 4) != 0);
            rdy = ($urandom_range(0, 599) == 0);
            d   = ($urandom_range(0, 63) == 0) ? 8'($urandom) : pattern(m_idx[0]);
            cyc(r, w, v, d, rdy);
        end
        idle_cyc();
        idle_cyc();

        // reset in the middle of a transfer, then a clean transfer
        good_bytes(500);
        do_reset();
        check_eq("t7_rst_xcnt", 32'(xcnt0), 32'd0);
        good_bytes(L);
        idle_cyc();
        check_eq("t7_pass", 32'(pass0), 32'd1);
        check_eq("t7_xcnt", 32'(xcnt0), 32'd1);
        idle_cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
